// File: rtl/cordic_asin_arb.sv
// rtl/cordic_asin_arb.sv - round-robin arbiter sharing one arcsin/arccos CORDIC pipeline
//
// Ports:
//   clk, rst_n                                   clock (rising edge), asynchronous active-low reset
//   req_vaild, req_data, req_ready               per-requester signed Q16.16 operand and accept
//   rsp_vaild, rsp_arcsin, rsp_arccos, rsp_err   per-requester held result (degrees, Q16.16)
//   rsp_ready                                    per-requester result consume
//   cordic_data, cordic_vaild                    registered issue to the shared CORDIC unit
//   cordic_arcsin, cordic_arccos, cordic_post_vaild  CORDIC results, LATENCY cycles after issue
//   sync_err                                     sticky tag/result misalignment flag
// Optional feature: define CORDIC_ARB_RANGE_CHECK_EN to clamp operands to +/-1.0 before
// issue and flag the clamped result with rsp_err; otherwise rsp_err is always 0.

module cordic_asin_arb #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_vaild,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_vaild,
    output logic [32*NUM_REQ-1:0]   rsp_arcsin,
    output logic [32*NUM_REQ-1:0]   rsp_arccos,
    output logic [NUM_REQ-1:0]      rsp_err,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             cordic_data,
    output logic                    cordic_vaild,
    input  logic [31:0]             cordic_arcsin,
    input  logic [31:0]             cordic_arccos,
    input  logic                    cordic_post_vaild,
    output logic                    sync_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0]   NREQ_W  = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);
`ifdef CORDIC_ARB_RANGE_CHECK_EN
    localparam logic signed [31:0] ONE_Q16 = 32'sd65536;
`endif

    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] rsp_hs;
    logic [NUM_REQ-1:0] eligible;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      grant_id;
    logic [IW:0]        idx;
    logic               grant;

    logic [31:0]        sel_data;
    logic [31:0]        issue_data_d;
    logic               sel_err;
    logic [IW-1:0]      issue_id;
    logic               issue_err;

    // Tag pipe travels beside the CORDIC unit so its tail lines up with cordic_post_vaild.
    logic               tag_v   [LATENCY];
    logic [IW-1:0]      tag_id  [LATENCY];
    logic               tag_err [LATENCY];
    logic               tail_v;
    logic [IW-1:0]      tail_id;
    logic               tail_err;

    assign tail_v   = tag_v[LATENCY-1];
    assign tail_id  = tag_id[LATENCY-1];
    assign tail_err = tag_err[LATENCY-1];

    // Round-robin grant starting at ptr.
    always_comb begin
        rsp_hs   = rsp_vaild & rsp_ready;
        // A requester whose result is consumed this cycle may be re-granted in the same cycle.
        eligible = req_vaild & (~busy | rsp_hs);
        grant    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!grant && eligible[idx[IW-1:0]]) begin
                grant    = 1'b1;
                grant_id = idx[IW-1:0];
            end
        end
        req_ready           = '0;
        req_ready[grant_id] = grant;
    end

    // Operand of the granted requester, optionally clamped to [-1.0, +1.0].
    always_comb begin
        sel_data     = req_data[{grant_id, 5'd0} +: 32];
        issue_data_d = sel_data;
        sel_err      = 1'b0;
`ifdef CORDIC_ARB_RANGE_CHECK_EN
        if ($signed(sel_data) > ONE_Q16) begin
            issue_data_d = ONE_Q16;
            sel_err      = 1'b1;
        end else if ($signed(sel_data) < -ONE_Q16) begin
            issue_data_d = -ONE_Q16;
            sel_err      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            ptr          <= '0;
            cordic_vaild <= 1'b0;
            cordic_data  <= '0;
            issue_id     <= '0;
            issue_err    <= 1'b0;
            rsp_vaild    <= '0;
            rsp_arcsin   <= '0;
            rsp_arccos   <= '0;
            rsp_err      <= '0;
            sync_err     <= 1'b0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_v[s]   <= 1'b0;
                tag_id[s]  <= '0;
                tag_err[s] <= 1'b0;
            end
        end else begin
            cordic_vaild <= grant;
            cordic_data  <= grant ? issue_data_d : 32'd0;
            issue_id     <= grant ? grant_id : '0;
            issue_err    <= grant & sel_err;

            tag_v[0]   <= cordic_vaild;
            tag_id[0]  <= issue_id;
            tag_err[0] <= issue_err;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_id[s]  <= tag_id[s-1];
                tag_err[s] <= tag_err[s-1];
            end

            // Set wins over clear so a same-cycle re-grant keeps busy high.
            busy <= (busy & ~rsp_hs) | req_ready;

            if (grant) begin
                ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end

            rsp_vaild <= rsp_vaild & ~rsp_hs;
            if (tail_v && cordic_post_vaild) begin
                rsp_vaild[tail_id]                 <= 1'b1;
                rsp_arcsin[{tail_id, 5'd0} +: 32]  <= cordic_arcsin;
                rsp_arccos[{tail_id, 5'd0} +: 32]  <= cordic_arccos;
                rsp_err[tail_id]                   <= tail_err;
            end

            // Mismatch means the tag pipe and CORDIC unit disagree; the result is dropped.
            if (tail_v != cordic_post_vaild) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule
